// File: rtl/dsp_mac_sequencer.sv
// Feeds a DSP48A1-style slice (A1/B1/M/OPMODE/P registered) so it accumulates one dot product
// per S_LAST-delimited vector, and buffers the final P values in a 2-entry FWFT FIFO.
module dsp_mac_sequencer #(
  parameter int unsigned PIPE_LAT = 3,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             S_VALID,
  output logic             S_READY,
  input  logic [17:0]      S_A,
  input  logic [17:0]      S_B,
  input  logic             S_LAST,
  output logic [17:0]      DSP_A,
  output logic [17:0]      DSP_B,
  output logic [7:0]       DSP_OPMODE,
  output logic             DSP_RST,
  input  logic [47:0]      DSP_P,
  output logic             M_VALID,
  input  logic             M_READY,
  output logic [47:0]      M_DATA,
  output logic [CNT_W-1:0] M_CNT
);

  typedef enum logic [0:0] {StIdle, StAccum} state_e;

  state_e           r_state;
  logic             r_dsp_rst;
  logic [17:0]      r_a;
  logic [17:0]      r_b;
  logic [CNT_W-1:0] r_cnt;

  logic [PIPE_LAT-1:0] r_tag_v;
  logic [PIPE_LAT-1:0] r_tag_last;
  logic [PIPE_LAT-2:0] r_tag_first;
  logic [CNT_W-1:0]    r_tag_cnt [PIPE_LAT];

  logic             r_cap;
  logic [CNT_W-1:0] r_cap_cnt;

  logic [47:0]      r_fifo_data [2];
  logic [CNT_W-1:0] r_fifo_cnt  [2];
  logic             r_rd_ptr;
  logic             r_wr_ptr;
  logic [1:0]       r_fifo_num;

  logic             w_accept;
  logic             w_first;
  logic             w_pop;
  logic [CNT_W-1:0] w_beat_cnt;
  logic [7:0]       w_outstanding;

  assign w_first    = (r_state == StIdle);
  assign w_accept   = S_VALID && S_READY;
  assign w_pop      = (r_fifo_num != 2'd0) && M_READY;
  assign w_beat_cnt = w_first ? CNT_W'(1) : r_cnt + CNT_W'(1);

  // Every last tag in flight already owns a FIFO slot, so the FIFO can never overflow.
  always_comb begin
    w_outstanding = 8'(r_cap) + 8'(r_fifo_num);
    for (int i = 0; i < PIPE_LAT; i++) begin
      w_outstanding = w_outstanding + 8'(r_tag_v[i] & r_tag_last[i]);
    end
  end

  assign S_READY = (w_outstanding < 8'd2) && !r_dsp_rst;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state   <= StIdle;
      r_dsp_rst <= 1'b1;
      r_a       <= '0;
      r_b       <= '0;
      r_cnt     <= '0;
    end else begin
      r_dsp_rst <= 1'b0;
      if (w_accept) begin
        r_a     <= S_A;
        r_b     <= S_B;
        r_cnt   <= w_beat_cnt;
        r_state <= S_LAST ? StIdle : StAccum;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_tag_v     <= '0;
      r_tag_last  <= '0;
      r_tag_first <= '0;
      for (int i = 0; i < PIPE_LAT; i++) r_tag_cnt[i] <= '0;
      r_cap       <= 1'b0;
      r_cap_cnt   <= '0;
    end else begin
      r_tag_v[0]     <= w_accept;
      r_tag_last[0]  <= w_accept && S_LAST;
      r_tag_first[0] <= w_first;
      r_tag_cnt[0]   <= w_beat_cnt;
      for (int i = 1; i < PIPE_LAT; i++) begin
        r_tag_v[i]    <= r_tag_v[i-1];
        r_tag_last[i] <= r_tag_last[i-1];
        r_tag_cnt[i]  <= r_tag_cnt[i-1];
      end
      for (int i = 1; i < PIPE_LAT - 1; i++) r_tag_first[i] <= r_tag_first[i-1];
      // P for the oldest stage lands on this edge; sample it one edge later.
      r_cap     <= r_tag_v[PIPE_LAT-1] && r_tag_last[PIPE_LAT-1];
      r_cap_cnt <= r_tag_cnt[PIPE_LAT-1];
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < 2; i++) begin
        r_fifo_data[i] <= '0;
        r_fifo_cnt[i]  <= '0;
      end
      r_rd_ptr   <= 1'b0;
      r_wr_ptr   <= 1'b0;
      r_fifo_num <= 2'd0;
    end else begin
      if (r_cap) begin
        r_fifo_data[r_wr_ptr] <= DSP_P;
        r_fifo_cnt[r_wr_ptr]  <= r_cap_cnt;
        r_wr_ptr              <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      case ({r_cap, w_pop})
        2'b10:   r_fifo_num <= r_fifo_num + 2'd1;
        2'b01:   r_fifo_num <= r_fifo_num - 2'd1;
        default: r_fifo_num <= r_fifo_num;
      endcase
    end
  end

  always_comb begin
    if (!r_tag_v[PIPE_LAT-2])         DSP_OPMODE = 8'h08;
    else if (r_tag_first[PIPE_LAT-2]) DSP_OPMODE = 8'h01;
    else                              DSP_OPMODE = 8'h09;
  end

  assign DSP_A   = r_a;
  assign DSP_B   = r_b;
  assign DSP_RST = r_dsp_rst;
  assign M_VALID = (r_fifo_num != 2'd0);
  assign M_DATA  = r_fifo_data[r_rd_ptr];
  assign M_CNT   = r_fifo_cnt[r_rd_ptr];

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Directed bench for dsp_mac_sequencer with a behavioural DSP48A1 slice
// (A1/B1/M/OPMODE/P registers, unsigned products) closing the loop on DSP_P.
module tb_dsp_mac_sequencer;

  localparam int unsigned PIPE_LAT = 3;
  localparam int unsigned CNT_W    = 16;

  logic             CLK;
  logic             RST_N;
  logic             S_VALID;
  logic             S_READY;
  logic [17:0]      S_A;
  logic [17:0]      S_B;
  logic             S_LAST;
  logic [17:0]      DSP_A;
  logic [17:0]      DSP_B;
  logic [7:0]       DSP_OPMODE;
  logic             DSP_RST;
  logic [47:0]      DSP_P;
  logic             M_VALID;
  logic             M_READY;
  logic [47:0]      M_DATA;
  logic [CNT_W-1:0] M_CNT;

  int vec_cnt = 0;
  int err_cnt = 0;

  dsp_mac_sequencer #(.PIPE_LAT(PIPE_LAT), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .S_VALID(S_VALID), .S_READY(S_READY), .S_A(S_A), .S_B(S_B), .S_LAST(S_LAST),
    .DSP_A(DSP_A), .DSP_B(DSP_B), .DSP_OPMODE(DSP_OPMODE), .DSP_RST(DSP_RST), .DSP_P(DSP_P),
    .M_VALID(M_VALID), .M_READY(M_READY), .M_DATA(M_DATA), .M_CNT(M_CNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Slice model
  logic [17:0] sl_a1, sl_b1;
  logic [35:0] sl_m;
  logic [7:0]  sl_opm;
  logic [47:0] sl_p, sl_x, sl_z;

  always_comb begin
    sl_x = (sl_opm[1:0] == 2'b01) ? {12'd0, sl_m} : 48'd0;
    sl_z = (sl_opm[3:2] == 2'b10) ? sl_p : 48'd0;
  end

  always @(posedge CLK) begin
    if (DSP_RST) begin
      sl_a1 <= '0; sl_b1 <= '0; sl_m <= '0; sl_opm <= '0; sl_p <= '0;
    end else begin
      sl_a1  <= DSP_A;
      sl_b1  <= DSP_B;
      sl_m   <= 36'(sl_a1) * 36'(sl_b1);
      sl_opm <= DSP_OPMODE;
      sl_p   <= sl_x + sl_z;
    end
  end

  assign DSP_P = sl_p;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, vectors=%0d", vec_cnt);
    $fatal(1);
  end

  task automatic send(input logic [17:0] a, input logic [17:0] b, input logic last);
    int n;
    n = 0;
    S_VALID = 1'b1; S_A = a; S_B = b; S_LAST = last;
    while (!S_READY && n < 50) begin @(negedge CLK); n++; end
    if (n >= 50) begin
      vec_cnt++; err_cnt++;
      $display("FAIL send_timeout: S_READY got 0 for %0d cycles, required 1", n);
    end
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic wait_valid(output int k);
    k = 0;
    while (!M_VALID && k < 40) begin @(negedge CLK); k++; end
  endtask

  task automatic test_reset();
    RST_N = 1'b1; S_VALID = 1'b0; S_A = '0; S_B = '0; S_LAST = 1'b0; M_READY = 1'b0;
    #1 RST_N = 1'b0;
    #1;
    vec_cnt++; if (S_READY !== 1'b0) begin err_cnt++; $display("FAIL rst_s_ready: got %0d want 0", S_READY); end
    vec_cnt++; if (M_VALID !== 1'b0) begin err_cnt++; $display("FAIL rst_m_valid: got %0d want 0", M_VALID); end
    vec_cnt++; if (M_DATA !== 48'd0) begin err_cnt++; $display("FAIL rst_m_data: got %0h want 0", M_DATA); end
    vec_cnt++; if (M_CNT !== 16'd0) begin err_cnt++; $display("FAIL rst_m_cnt: got %0h want 0", M_CNT); end
    vec_cnt++; if (DSP_A !== 18'd0 || DSP_B !== 18'd0) begin err_cnt++; $display("FAIL rst_dsp_ab: got %0h/%0h want 0/0", DSP_A, DSP_B); end
    vec_cnt++; if (DSP_OPMODE !== 8'h08) begin err_cnt++; $display("FAIL rst_opmode: got %0h want 08", DSP_OPMODE); end
    vec_cnt++; if (DSP_RST !== 1'b1) begin err_cnt++; $display("FAIL rst_dsp_rst: got %0d want 1", DSP_RST); end
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    #1;
    vec_cnt++; if (DSP_RST !== 1'b1 || S_READY !== 1'b0) begin err_cnt++; $display("FAIL rel_hold: dsp_rst=%0d s_ready=%0d want 1/0", DSP_RST, S_READY); end
    @(negedge CLK);
    vec_cnt++; if (DSP_RST !== 1'b0 || S_READY !== 1'b1) begin err_cnt++; $display("FAIL rel_drop: dsp_rst=%0d s_ready=%0d want 0/1", DSP_RST, S_READY); end
  endtask

  task automatic test_single_vector();
    int k;
    M_READY = 1'b1;
    send(18'd1, 18'd2, 1'b0);
    send(18'd3, 18'd4, 1'b0);
    send(18'd5, 18'd6, 1'b1);
    S_VALID = 1'b0;
    wait_valid(k);
    vec_cnt++; if (k != PIPE_LAT + 1) begin err_cnt++; $display("FAIL single_latency: got %0d want %0d", k, PIPE_LAT + 1); end
    vec_cnt++; if (M_DATA !== 48'd44) begin err_cnt++; $display("FAIL single_data: got %0d want 44", M_DATA); end
    vec_cnt++; if (M_CNT !== 16'd3) begin err_cnt++; $display("FAIL single_cnt: got %0d want 3", M_CNT); end
    @(negedge CLK);
    vec_cnt++; if (M_VALID !== 1'b0) begin err_cnt++; $display("FAIL single_pulse: M_VALID got %0d want 0", M_VALID); end
    repeat (4) @(negedge CLK);
    vec_cnt++; if (M_VALID !== 1'b0) begin err_cnt++; $display("FAIL single_extra: M_VALID got %0d want 0", M_VALID); end
  endtask

  task automatic test_back_to_back();
    int k;
    send(18'd7, 18'd9, 1'b1);
    send(18'd2, 18'd2, 1'b1);
    S_VALID = 1'b0;
    wait_valid(k);
    vec_cnt++; if (M_DATA !== 48'd63 || M_CNT !== 16'd1) begin err_cnt++; $display("FAIL b2b_first: got %0d/%0d want 63/1", M_DATA, M_CNT); end
    @(negedge CLK);
    vec_cnt++; if (M_VALID !== 1'b1 || M_DATA !== 48'd4 || M_CNT !== 16'd1) begin err_cnt++; $display("FAIL b2b_second: got v=%0d %0d/%0d want 1 4/1", M_VALID, M_DATA, M_CNT); end
    @(negedge CLK);
    vec_cnt++; if (M_VALID !== 1'b0) begin err_cnt++; $display("FAIL b2b_empty: M_VALID got %0d want 0", M_VALID); end
  endtask

  task automatic test_bubbles();
    int k;
    send(18'd10, 18'd10, 1'b0);
    S_VALID = 1'b0;
    @(negedge CLK);
    vec_cnt++; if (DSP_OPMODE !== 8'h01) begin err_cnt++; $display("FAIL bub_op_first: got %0h want 01", DSP_OPMODE); end
    @(negedge CLK);
    vec_cnt++; if (DSP_OPMODE !== 8'h08) begin err_cnt++; $display("FAIL bub_op_hold1: got %0h want 08", DSP_OPMODE); end
    @(negedge CLK);
    vec_cnt++; if (DSP_OPMODE !== 8'h08) begin err_cnt++; $display("FAIL bub_op_hold2: got %0h want 08", DSP_OPMODE); end
    send(18'd10, 18'd10, 1'b1);
    S_VALID = 1'b0;
    vec_cnt++; if (DSP_OPMODE !== 8'h08) begin err_cnt++; $display("FAIL bub_op_hold3: got %0h want 08", DSP_OPMODE); end
    @(negedge CLK);
    vec_cnt++; if (DSP_OPMODE !== 8'h09) begin err_cnt++; $display("FAIL bub_op_accum: got %0h want 09", DSP_OPMODE); end
    wait_valid(k);
    vec_cnt++; if (M_DATA !== 48'd200 || M_CNT !== 16'd2) begin err_cnt++; $display("FAIL bub_result: got %0d/%0d want 200/2", M_DATA, M_CNT); end
    @(negedge CLK);
  endtask

  task automatic test_backpressure();
    int k;
    M_READY = 1'b0;
    send(18'd2, 18'd3, 1'b1);
    send(18'd4, 18'd5, 1'b1);
    S_VALID = 1'b1; S_A = 18'd6; S_B = 18'd7; S_LAST = 1'b1;
    for (int i = 0; i < 5; i++) begin
      vec_cnt++; if (S_READY !== 1'b0) begin err_cnt++; $display("FAIL bp_stall%0d: S_READY got %0d want 0", i, S_READY); end
      @(negedge CLK);
    end
    vec_cnt++; if (M_VALID !== 1'b1 || M_DATA !== 48'd6 || M_CNT !== 16'd1) begin err_cnt++; $display("FAIL bp_head1: got v=%0d %0d/%0d want 1 6/1", M_VALID, M_DATA, M_CNT); end
    vec_cnt++; if (S_READY !== 1'b0) begin err_cnt++; $display("FAIL bp_full: S_READY got %0d want 0", S_READY); end
    M_READY = 1'b1;
    @(negedge CLK);
    M_READY = 1'b0;
    vec_cnt++; if (M_DATA !== 48'd20 || S_READY !== 1'b1) begin err_cnt++; $display("FAIL bp_pop1: got data=%0d s_ready=%0d want 20/1", M_DATA, S_READY); end
    @(posedge CLK);
    @(negedge CLK);
    S_VALID = 1'b0;
    vec_cnt++; if (M_VALID !== 1'b1 || M_DATA !== 48'd20) begin err_cnt++; $display("FAIL bp_head2: got v=%0d %0d want 1 20", M_VALID, M_DATA); end
    M_READY = 1'b1;
    @(negedge CLK);
    vec_cnt++; if (M_VALID !== 1'b0) begin err_cnt++; $display("FAIL bp_drain: M_VALID got %0d want 0", M_VALID); end
    wait_valid(k);
    vec_cnt++; if (M_DATA !== 48'd42 || M_CNT !== 16'd1) begin err_cnt++; $display("FAIL bp_third: got %0d/%0d want 42/1", M_DATA, M_CNT); end
    @(negedge CLK);
  endtask

  task automatic test_max_operands();
    int k;
    M_READY = 1'b1;
    for (int i = 0; i < 4999; i++) send(18'h3FFFF, 18'h3FFFF, 1'b0);
    send(18'h3FFFF, 18'h3FFFF, 1'b1);
    S_VALID = 1'b0;
    wait_valid(k);
    // 5000 * 0xF_FFF8_0001 mod 2^48
    vec_cnt++; if (M_DATA !== 48'd62119785534344) begin err_cnt++; $display("FAIL max_data: got %0d want 62119785534344", M_DATA); end
    vec_cnt++; if (M_CNT !== 16'd5000) begin err_cnt++; $display("FAIL max_cnt: got %0d want 5000", M_CNT); end
    @(negedge CLK);
  endtask

  task automatic test_reset_mid();
    int k;
    M_READY = 1'b0;
    send(18'd5, 18'd5, 1'b1);
    send(18'd1, 18'd1, 1'b0);
    send(18'd2, 18'd2, 1'b0);
    S_VALID = 1'b0;
    wait_valid(k);
    vec_cnt++; if (M_DATA !== 48'd25) begin err_cnt++; $display("FAIL mid_pre: got %0d want 25", M_DATA); end
    send(18'd3, 18'd1, 1'b0);
    S_VALID = 1'b0;
    RST_N = 1'b0;
    #1;
    vec_cnt++; if (M_VALID !== 1'b0 || M_DATA !== 48'd0 || M_CNT !== 16'd0) begin err_cnt++; $display("FAIL mid_rst_m: got v=%0d %0d/%0d want 0 0/0", M_VALID, M_DATA, M_CNT); end
    vec_cnt++; if (DSP_A !== 18'd0 || DSP_B !== 18'd0) begin err_cnt++; $display("FAIL mid_rst_ab: got %0h/%0h want 0/0", DSP_A, DSP_B); end
    vec_cnt++; if (DSP_OPMODE !== 8'h08 || DSP_RST !== 1'b1 || S_READY !== 1'b0) begin err_cnt++; $display("FAIL mid_rst_ctl: got op=%0h rst=%0d rdy=%0d want 08 1 0", DSP_OPMODE, DSP_RST, S_READY); end
    @(negedge CLK);
    RST_N = 1'b1;
    #1;
    vec_cnt++; if (DSP_RST !== 1'b1) begin err_cnt++; $display("FAIL mid_rel_hold: DSP_RST got %0d want 1", DSP_RST); end
    @(negedge CLK);
    vec_cnt++; if (DSP_RST !== 1'b0) begin err_cnt++; $display("FAIL mid_rel_drop: DSP_RST got %0d want 0", DSP_RST); end
    M_READY = 1'b1;
    send(18'd3, 18'd3, 1'b1);
    S_VALID = 1'b0;
    wait_valid(k);
    vec_cnt++; if (k != PIPE_LAT + 1) begin err_cnt++; $display("FAIL mid_latency: got %0d want %0d", k, PIPE_LAT + 1); end
    vec_cnt++; if (M_DATA !== 48'd9 || M_CNT !== 16'd1) begin err_cnt++; $display("FAIL mid_after: got %0d/%0d want 9/1", M_DATA, M_CNT); end
    @(negedge CLK);
  endtask

  initial begin
    test_reset();
    test_single_vector();
    test_back_to_back();
    test_bubbles();
    test_backpressure();
    test_max_operands();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
